ijtc_gshare_predictor: RTL and testbench

Parametrised gshare-indexed indirect jump target predictor for the IF stage. It predicts the targets of `jr`/`jalr` (`$1`–`$30`) for every slot of an aligned fetch block. It returns a per-slot GHR checkpoint that the back-end hands back on repair. On a miss it falls back to slot PC + 8. It replaces the fixed 4-slot stub with a real tagged table, a speculative GHR, checkpoint-based repair and a reset sweep.

---
 rtl/ijtc_pkg.sv | 31 +++
 rtl/ijtc_table.sv | 38 +++
 rtl/ijtc_gshare_predictor.sv | 141 ++++++++++++++
 tb/tb_ijtc_gshare_predictor.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ijtc_pkg.sv
// Shared types and hashing for the gshare indirect jump target predictor.
// Table entries carry a tag field sized for the widest legal TAG_LEN.
package ijtc_pkg;

  localparam int IJTC_TAG_MAX = 29;

  typedef enum logic {
    IJTC_INIT = 1'b0,
    IJTC_RUN  = 1'b1
  } ijtc_state_e;

  typedef struct packed {
    logic                    valid;
    logic [IJTC_TAG_MAX-1:0] tag;
    logic [31:0]             target;
  } ijtc_entry_t;

  localparam int IJTC_ENTRY_W = $bits(ijtc_entry_t);

  // gshare index: word-address bits above the byte offset, XORed with the zero-extended history.
  function automatic logic [31:0] ijtc_index(input logic [31:0] pc, input logic [31:0] ghr,
                                             input int idx_len);
    return ((pc >> 2) ^ ghr) & ((32'd1 << idx_len) - 32'd1);
  endfunction

  function automatic logic [31:0] ijtc_tag(input logic [31:0] pc, input int idx_len,
                                           input int tag_len);
    return (pc >> (2 + idx_len)) & ((32'd1 << tag_len) - 32'd1);
  endfunction

endpackage

// File: rtl/ijtc_table.sv
// Target table: register array with FETCH_WIDTH async read ports,
// one synchronous write port and a one-entry-per-cycle valid clear.
module ijtc_table
  import ijtc_pkg::*;
#(
  parameter int ENTRIES     = 256,
  parameter int FETCH_WIDTH = 4,
  parameter int IDX_LEN     = 8
) (
  input  logic                               clk,
  input  logic                               clr_en,
  input  logic [IDX_LEN-1:0]                 clr_idx,
  input  logic                               wr_en,
  input  logic [IDX_LEN-1:0]                 wr_idx,
  input  logic [IJTC_ENTRY_W-1:0]            wr_data,
  input  logic [FETCH_WIDTH*IDX_LEN-1:0]     rd_idx,
  output logic [FETCH_WIDTH*IJTC_ENTRY_W-1:0] rd_data
);

  ijtc_entry_t mem [ENTRIES];

  // Clear and write never coincide: the owner only clears in INIT and only writes in RUN.
  always_ff @(posedge clk) begin
    if (clr_en) begin
      mem[clr_idx].valid <= 1'b0;
    end else if (wr_en) begin
      mem[wr_idx] <= wr_data;
    end
  end

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      rd_data[i*IJTC_ENTRY_W +: IJTC_ENTRY_W] = mem[rd_idx[i*IDX_LEN +: IDX_LEN]];
    end
  end

endmodule

// File: rtl/ijtc_gshare_predictor.sv
// gshare-indexed indirect jump target predictor: FSM with reset sweep, speculative GHR
// with checkpoint repair, per-slot lookup with PC+8 fall-back and registered response.
module ijtc_gshare_predictor
  import ijtc_pkg::*;
#(
  parameter int FETCH_WIDTH = 4,
  parameter int ENTRIES     = 256,
  parameter int GHR_LEN     = 8,
  parameter int TAG_LEN     = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           req_valid,
  output logic                           req_ready,
  input  logic [31:0]                    req_vaddr,
  output logic                           resp_valid,
  output logic [FETCH_WIDTH-1:0]         resp_hit,
  output logic [FETCH_WIDTH*32-1:0]      resp_dest,
  output logic [FETCH_WIDTH*GHR_LEN-1:0] resp_ckpt,
  input  logic                           spec_valid,
  input  logic                           spec_take,
  input  logic                           rep_valid,
  input  logic [GHR_LEN-1:0]             rep_ckpt,
  input  logic                           rep_take,
  input  logic                           rep_write,
  input  logic [31:0]                    rep_vaddr,
  input  logic [31:0]                    rep_dest
);

  localparam int IDX_LEN = $clog2(ENTRIES);

  ijtc_state_e                         state_q, state_d;
  logic [IDX_LEN-1:0]                  ptr_q;
  logic [GHR_LEN-1:0]                  ghr_q, ghr_d;

  logic                                vld_p0;
  logic [31:0]                         pc_p0  [FETCH_WIDTH];
  ijtc_entry_t                         ent_p0 [FETCH_WIDTH];
  logic [FETCH_WIDTH*IDX_LEN-1:0]      rd_idx_p0;
  logic [FETCH_WIDTH*IJTC_ENTRY_W-1:0] rd_data_p0;
  logic [FETCH_WIDTH-1:0]              hit_p0;
  logic [FETCH_WIDTH*32-1:0]           dest_p0;

  logic                                wr_en;
  logic [IDX_LEN-1:0]                  wr_idx;
  ijtc_entry_t                         wr_entry;

  assign req_ready = (state_q == IJTC_RUN);
  assign vld_p0    = req_valid && req_ready;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IJTC_INIT: if (ptr_q == IDX_LEN'(ENTRIES - 1)) state_d = IJTC_RUN;
      IJTC_RUN:  state_d = IJTC_RUN;
      default:   state_d = IJTC_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IJTC_INIT;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IJTC_INIT) ptr_q <= ptr_q + 1'b1;
    end
  end

  // Repair restores the checkpoint shifted by the resolved direction and wins over speculation.
  always_comb begin
    ghr_d = ghr_q;
    if (rep_valid) begin
      ghr_d = GHR_LEN'({rep_ckpt, rep_take});
    end else if (spec_valid) begin
      ghr_d = GHR_LEN'({ghr_q, spec_take});
    end
  end

  // ---- p0: slot PCs and table indices ----
  always_comb begin
    rd_idx_p0 = '0;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      pc_p0[i] = req_vaddr + 32'(4 * i);
      rd_idx_p0[i*IDX_LEN +: IDX_LEN] = IDX_LEN'(ijtc_index(pc_p0[i], 32'(ghr_q), IDX_LEN));
    end
  end

  ijtc_table #(
    .ENTRIES     (ENTRIES),
    .FETCH_WIDTH (FETCH_WIDTH),
    .IDX_LEN     (IDX_LEN)
  ) u_table (
    .clk     (clk),
    .clr_en  (state_q == IJTC_INIT),
    .clr_idx (ptr_q),
    .wr_en   (wr_en),
    .wr_idx  (wr_idx),
    .wr_data (wr_entry),
    .rd_idx  (rd_idx_p0),
    .rd_data (rd_data_p0)
  );

  // ---- p0: tag compare and fall-back target ----
  always_comb begin
    hit_p0  = '0;
    dest_p0 = '0;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      ent_p0[i] = rd_data_p0[i*IJTC_ENTRY_W +: IJTC_ENTRY_W];
      hit_p0[i] = ent_p0[i].valid &&
                  (ent_p0[i].tag == IJTC_TAG_MAX'(ijtc_tag(pc_p0[i], IDX_LEN, TAG_LEN)));
      dest_p0[i*32 +: 32] = hit_p0[i] ? ent_p0[i].target : pc_p0[i] + 32'd8;
    end
  end

  assign wr_en    = rep_valid && rep_write && (state_q == IJTC_RUN);
  assign wr_idx   = IDX_LEN'(ijtc_index(rep_vaddr, 32'(rep_ckpt), IDX_LEN));
  assign wr_entry = '{valid:  1'b1,
                      tag:    IJTC_TAG_MAX'(ijtc_tag(rep_vaddr, IDX_LEN, TAG_LEN)),
                      target: rep_dest};

  // ---- p1: response registers, data held until the next accept ----
  always_ff @(posedge clk) begin
    if (rst) begin
      ghr_q      <= '0;
      resp_valid <= 1'b0;
      resp_hit   <= '0;
      resp_dest  <= '0;
      resp_ckpt  <= '0;
    end else begin
      ghr_q      <= ghr_d;
      resp_valid <= vld_p0;
      if (vld_p0) begin
        resp_hit  <= hit_p0;
        resp_dest <= dest_p0;
        resp_ckpt <= {FETCH_WIDTH{ghr_q}};
      end
    end
  end

endmodule

// File: tb/tb_ijtc_gshare_predictor.sv
// Bench for ijtc_gshare_predictor: reference model plus scoreboard queue, a vector table
// of lookup/repair cycles and hand sequences for the reset sweep corner cases.
module tb_ijtc_gshare_predictor;

  localparam int FW  = 4;
  localparam int ENT = 256;
  localparam int GL  = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic [31:0]   req_vaddr;
  logic          resp_valid;
  logic [FW-1:0] resp_hit;
  logic [FW*32-1:0] resp_dest;
  logic [FW*GL-1:0] resp_ckpt;
  logic          spec_valid, spec_take;
  logic          rep_valid, rep_take, rep_write;
  logic [GL-1:0] rep_ckpt;
  logic [31:0]   rep_vaddr, rep_dest;

  always #5 clk = ~clk;

  ijtc_gshare_predictor #(.FETCH_WIDTH(FW), .ENTRIES(ENT), .GHR_LEN(GL), .TAG_LEN(8)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_vaddr(req_vaddr),
    .resp_valid(resp_valid), .resp_hit(resp_hit), .resp_dest(resp_dest), .resp_ckpt(resp_ckpt),
    .spec_valid(spec_valid), .spec_take(spec_take), .rep_valid(rep_valid), .rep_ckpt(rep_ckpt),
    .rep_take(rep_take), .rep_write(rep_write), .rep_vaddr(rep_vaddr), .rep_dest(rep_dest)
  );

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [FW-1:0]    hit;
    logic [FW*32-1:0] dest;
    logic [FW*GL-1:0] ckpt;
  } resp_t;

  resp_t sb_q[$];
  resp_t last;

  bit          m_valid  [ENT];
  logic [7:0]  m_tag    [ENT];
  logic [31:0] m_target [ENT];
  logic [7:0]  m_ghr;
  bit          m_run;
  int          m_ptr;

  typedef struct {
    bit          req;
    logic [31:0] vaddr;
    bit          spec;
    bit          spec_take;
    bit          rep;
    bit          wr;
    logic [31:0] rep_vaddr;
    logic [7:0]  rep_ckpt;
    bit          rep_take;
    logic [31:0] rep_dest;
    logic [3:0]  exp_hit;
    logic [7:0]  exp_ckpt;
    logic [31:0] exp_dest1;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] m_idx(input logic [31:0] pc, input logic [7:0] g);
    return pc[9:2] ^ g;
  endfunction

  task automatic model_reset();
    m_run = 1'b0;
    m_ptr = 0;
    m_ghr = 8'h00;
    for (int k = 0; k < ENT; k++) begin
      m_valid[k]  = 1'b0;
      m_tag[k]    = 8'h00;
      m_target[k] = 32'h0;
    end
    last.hit  = '0;
    last.dest = '0;
    last.ckpt = '0;
  endtask

  // One clock: predict, push expectation, advance model at the edge, compare 1 ns later.
  task automatic step();
    bit          acc;
    resp_t       e;
    logic [31:0] pc;
    logic [7:0]  ix;
    bit          h;
    chk("req_ready", req_ready, m_run);
    acc = req_valid && m_run && !rst;
    if (acc) begin
      for (int i = 0; i < FW; i++) begin
        pc = req_vaddr + 32'(4 * i);
        ix = m_idx(pc, m_ghr);
        h  = m_valid[ix] && (m_tag[ix] == pc[17:10]);
        e.hit[i]          = h;
        e.dest[32*i +: 32] = h ? m_target[ix] : pc + 32'd8;
        e.ckpt[GL*i +: GL] = m_ghr;
      end
      sb_q.push_back(e);
    end
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      if (rep_valid && rep_write && m_run) begin
        ix = m_idx(rep_vaddr, rep_ckpt);
        m_valid[ix]  = 1'b1;
        m_tag[ix]    = rep_vaddr[17:10];
        m_target[ix] = rep_dest;
      end
      if (rep_valid)       m_ghr = {rep_ckpt[6:0], rep_take};
      else if (spec_valid) m_ghr = {m_ghr[6:0], spec_take};
      if (!m_run) begin
        if (m_ptr == ENT - 1) m_run = 1'b1;
        m_ptr++;
      end
    end
    #1;
    chk("resp_valid", resp_valid, acc);
    if (acc && sb_q.size() > 0) begin
      e    = sb_q.pop_front();
      last = e;
    end else begin
      e = last;
    end
    chk("resp_hit", resp_hit, e.hit);
    chk("resp_dest", resp_dest, e.dest);
    chk("resp_ckpt", resp_ckpt, e.ckpt);
  endtask

  task automatic idle_inputs();
    spec_valid = 0; spec_take = 0;
    rep_valid = 0; rep_write = 0; rep_take = 0;
    rep_ckpt = '0; rep_vaddr = '0; rep_dest = '0;
  endtask

  // Steps through INIT with req_valid held; optionally fires one repair write at cycle wr_at.
  task automatic sweep(input int wr_at, output int n);
    n = 0;
    while (!req_ready && n < 400) begin
      idle_inputs();
      if (n == wr_at) begin
        rep_valid = 1; rep_write = 1; rep_vaddr = 32'h8000_0014;
        rep_ckpt = 8'h00; rep_take = 0; rep_dest = 32'hDEAD_BEE0;
      end
      step();
      n++;
    end
    idle_inputs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    rst = 1; req_valid = 1; req_vaddr = 32'h8000_0010;
    idle_inputs();
    model_reset();
    @(posedge clk);
    #1;

    // Reset sweep with requests held high
    repeat (2) step();
    chk("rst_ready", req_ready, 1'b0);
    rst = 0;
    sweep(-1, n);
    chk("init_len", n, 256);

    // Cold miss
    req_valid = 1; req_vaddr = 32'h8000_0010;
    step();
    chk("cold_dest", resp_dest, 128'h80000024_80000020_8000001C_80000018);
    chk("cold_hit", resp_hit, 4'h0);
    req_valid = 0;

    //            req vaddr          spec tk rep wr rep_vaddr       ckpt  tk dest             hit   ckpt  dest1
    vecs.push_back('{0, 32'h0,        0, 0, 1, 1, 32'h8000_0014, 8'h00, 1, 32'hBFC0_0380, 4'h0, 8'h00, 32'h0});
    vecs.push_back('{1, 32'h8000_0010, 0, 0, 0, 0, 32'h0,         8'h00, 0, 32'h0,         4'h1, 8'h01, 32'h8000_001C});
    vecs.push_back('{0, 32'h0,        0, 0, 1, 0, 32'h0,         8'h00, 0, 32'h0,         4'h0, 8'h00, 32'h0});
    vecs.push_back('{1, 32'h8000_0010, 0, 0, 0, 0, 32'h0,         8'h00, 0, 32'h0,         4'h2, 8'h00, 32'hBFC0_0380});
    vecs.push_back('{1, 32'h8000_0410, 0, 0, 0, 0, 32'h0,         8'h00, 0, 32'h0,         4'h0, 8'h00, 32'h8000_041C});
    vecs.push_back('{0, 32'h0,        0, 0, 1, 0, 32'h0,         8'h55, 0, 32'h0,         4'h0, 8'h00, 32'h0});
    vecs.push_back('{1, 32'h8000_0010, 0, 0, 0, 0, 32'h0,         8'h00, 0, 32'h0,         4'h0, 8'hAA, 32'h8000_001C});
    vecs.push_back('{1, 32'h8000_0010, 1, 1, 1, 0, 32'h0,         8'h0F, 0, 32'h0,         4'h0, 8'hAA, 32'h8000_001C});
    vecs.push_back('{1, 32'h8000_0010, 0, 0, 0, 0, 32'h0,         8'h00, 0, 32'h0,         4'h0, 8'h1E, 32'h8000_001C});
    vecs.push_back('{0, 32'h0,        1, 1, 0, 0, 32'h0,         8'h00, 0, 32'h0,         4'h0, 8'h00, 32'h0});
    vecs.push_back('{1, 32'h8000_0010, 0, 0, 0, 0, 32'h0,         8'h00, 0, 32'h0,         4'h0, 8'h3D, 32'h8000_001C});
    vecs.push_back('{0, 32'h0,        0, 0, 1, 0, 32'h0,         8'h00, 0, 32'h0,         4'h0, 8'h00, 32'h0});
    vecs.push_back('{1, 32'h8000_0020, 0, 0, 1, 1, 32'h8000_0024, 8'h00, 0, 32'h1234_5678, 4'h0, 8'h00, 32'h8000_002C});
    vecs.push_back('{1, 32'h8000_0020, 0, 0, 0, 0, 32'h0,         8'h00, 0, 32'h0,         4'h2, 8'h00, 32'h1234_5678});
    vecs.push_back('{1, 32'h8000_0010, 0, 0, 1, 1, 32'h8000_0014, 8'h00, 0, 32'hCAFE_F00C, 4'h2, 8'h00, 32'hBFC0_0380});
    vecs.push_back('{1, 32'h8000_0010, 0, 0, 0, 0, 32'h0,         8'h00, 0, 32'h0,         4'h2, 8'h00, 32'hCAFE_F00C});
    vecs.push_back('{0, 32'h0,        0, 0, 0, 0, 32'h0,         8'h00, 0, 32'h0,         4'h0, 8'h00, 32'h0});
    vecs.push_back('{0, 32'h0,        0, 0, 1, 1, 32'h8000_0030, 8'h03, 1, 32'h0000_1000, 4'h0, 8'h00, 32'h0});
    vecs.push_back('{1, 32'h8000_0030, 0, 0, 0, 0, 32'h0,         8'h00, 0, 32'h0,         4'h4, 8'h07, 32'h8000_003C});
    vecs.push_back('{0, 32'h0,        0, 0, 1, 0, 32'h0,         8'h01, 1, 32'h0,         4'h0, 8'h00, 32'h0});
    vecs.push_back('{1, 32'h8000_0030, 0, 0, 0, 0, 32'h0,         8'h00, 0, 32'h0,         4'h1, 8'h03, 32'h8000_003C});

    for (int k = 0; k < vecs.size(); k++) begin
      req_valid  = vecs[k].req;
      req_vaddr  = vecs[k].vaddr;
      spec_valid = vecs[k].spec;
      spec_take  = vecs[k].spec_take;
      rep_valid  = vecs[k].rep;
      rep_write  = vecs[k].wr;
      rep_vaddr  = vecs[k].rep_vaddr;
      rep_ckpt   = vecs[k].rep_ckpt;
      rep_take   = vecs[k].rep_take;
      rep_dest   = vecs[k].rep_dest;
      step();
      if (vecs[k].req) begin
        chk($sformatf("vec%0d_hit", k), resp_hit, vecs[k].exp_hit);
        chk($sformatf("vec%0d_ckpt", k), resp_ckpt[7:0], vecs[k].exp_ckpt);
        chk($sformatf("vec%0d_dest1", k), resp_dest[63:32], vecs[k].exp_dest1);
      end
    end
    idle_inputs();
    req_valid = 0;

    // Reset in RUN, then again at INIT cycle 100; a write during INIT must be dropped
    rst = 1;
    step();
    rst = 0; req_valid = 1; req_vaddr = 32'h8000_0010;
    repeat (100) step();
    rst = 1;
    step();
    rst = 0;
    sweep(50, n);
    chk("reinit_len", n, 256);
    step();
    chk("post_sweep_hit", resp_hit, 4'h0);
    chk("post_sweep_dest1", resp_dest[63:32], 32'h8000_001C);
    req_valid = 0;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
